// File: rtl/mcb_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_cmd_arbiter
//  Purpose  : Shares the single MCB command port of the LPDDR controller
//             between two requesters. Port 0 (VGA scanline prefetch) has
//             priority. Port 1 (CPU) is guaranteed service after at most
//             STARVE_LIMIT consecutive port-0 grants made while it waited.
//             No command is issued before memory calibration completes, and
//             mem_cmd_full is always honoured.
//  Ports    : clk, rst_n            - clock, synchronous active-low reset
//             calib_done            - MCB calibration complete
//             rN_req/instr/bl/addr  - requester N command (held until rN_ack)
//             rN_ack                - 1-cycle pulse when N's command is written
//             mem_cmd_*             - MCB command port (fields are registered)
//             mem_cmd_full          - MCB command FIFO full
//             grant_id              - owner of the latched/issuing command
//             busy                  - a command is latched and awaiting issue
//  Revision : 1.0 - initial release
// ============================================================================
module mcb_cmd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic        r0_req,
    input  logic [2:0]  r0_instr,
    input  logic [5:0]  r0_bl,
    input  logic [29:0] r0_addr,
    output logic        r0_ack,
    input  logic        r1_req,
    input  logic [2:0]  r1_instr,
    input  logic [5:0]  r1_bl,
    input  logic [29:0] r1_addr,
    output logic        r1_ack,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        grant_id,
    output logic        busy
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;
    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [0:0]  r_state;
    logic [3:0]  r_starve_cnt;
    logic        r_grant;
    logic [2:0]  r_instr;
    logic [5:0]  r_bl;
    logic [29:0] r_addr;

    logic        w_pick1;
    logic        w_latch;
    logic        w_fire;
    logic [29:0] w_addr_sel;
    logic [3:0]  w_starve_next;

    // Port 1 wins when alone, or when port 0 has used up its allowance of
    // consecutive grants while port 1 was waiting.
    assign w_pick1 = r1_req && (!r0_req || (r_starve_cnt == c_LIMIT));

    assign w_latch = (r_state == c_IDLE)  && calib_done && (r0_req || r1_req);
    assign w_fire  = (r_state == c_ISSUE) && calib_done && !mem_cmd_full;

    assign w_addr_sel = w_pick1 ? r1_addr : r0_addr;

    // Counts port-0 grants that bypassed a waiting port 1; any other grant
    // clears it.
    always_comb begin
        w_starve_next = 4'd0;
        if (!w_pick1 && r1_req) begin
            w_starve_next = (r_starve_cnt == c_LIMIT) ? r_starve_cnt
                                                      : r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_starve_cnt <= 4'd0;
            r_grant      <= 1'b0;
            r_instr      <= 3'd0;
            r_bl         <= 6'd0;
            r_addr       <= 30'd0;
        end else if (r_state == c_IDLE) begin
            if (w_latch) begin
                r_state      <= c_ISSUE;
                r_grant      <= w_pick1;
                r_instr      <= w_pick1 ? r1_instr : r0_instr;
                r_bl         <= w_pick1 ? r1_bl    : r0_bl;
                // MCB byte addresses are word aligned.
                r_addr       <= w_addr_sel & ~30'h3;
                r_starve_cnt <= w_starve_next;
            end
        end else begin
            // Command is held (not dropped) while full or uncalibrated.
            if (w_fire) begin
                r_state <= c_IDLE;
            end
        end
    end

    // Strobe is combinational on mem_cmd_full so it can never assert while
    // the FIFO is full; ack is the same strobe steered to the owner.
    assign mem_cmd_en        = w_fire;
    assign r0_ack            = w_fire && !r_grant;
    assign r1_ack            = w_fire &&  r_grant;
    assign mem_cmd_instr     = r_instr;
    assign mem_cmd_bl        = r_bl;
    assign mem_cmd_byte_addr = r_addr;
    assign grant_id          = r_grant;
    assign busy              = (r_state == c_ISSUE);

endmodule
`default_nettype wire
